// File: rtl/digit_serial_alu.sv
// digit_serial_alu: digit-serial ADD/SUB/AND/OR/XOR engine, one DIGIT-bit digit per clock, LSB digit first.
// Ports: i_clk, i_rst_n (async active-low), i_start (accepted when idle), i_op (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5-7 ADD),
//        i_word1 (operand A), i_word2 (operand B, low (i_len+1) digits significant), i_len (active digits of B minus one),
//        i_sext (sign-extend B), o_busy, o_done (one-cycle pulse), o_result (held until next start), o_carry_out.
// Optional: define DSALU_EARLY_EXIT_EN to let ADD/SUB stop once the remaining digits are provably unchanged.
module digit_serial_alu #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4,
  localparam int NDIG = WIDTH / DIGIT,
  localparam int LW = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_word1,
  input  logic [WIDTH-1:0] i_word2,
  input  logic [LW-1:0]    i_len,
  input  logic             i_sext,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry_out
);
  typedef enum logic {S_IDLE, S_RUN} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_b, r_result, w_b_ext, w_mask, w_dw;
  logic [LW-1:0] r_idx, w_len;
  logic r_sub, r_and, r_or, r_logic, r_carry, r_done, r_cout;
  logic w_sign, w_acc, w_last, w_early;
  logic [31:0] w_pos;
  logic [DIGIT-1:0] w_ad, w_bd, w_lg;
  logic [DIGIT:0] w_d;
  // Clamp only exists when i_len can encode digits beyond NDIG-1.
  if ((1 << LW) == NDIG) begin : g_nc
    assign w_len = i_len;
  end else begin : g_c
    assign w_len = (i_len > LW'(NDIG - 1)) ? LW'(NDIG - 1) : i_len;
  end
  always_comb begin
    w_sign = 1'b0;
    w_b_ext = '0;
    for (int j = 0; j < NDIG; j++)
      if (LW'(j) == w_len) w_sign = i_sext & i_word2[j*DIGIT+DIGIT-1];
    for (int j = 0; j < NDIG; j++)
      w_b_ext[j*DIGIT +: DIGIT] = (LW'(j) <= w_len) ? i_word2[j*DIGIT +: DIGIT] : {DIGIT{w_sign}};
  end
  // Digits of A at and above idx are still the preloaded word1 inside r_result.
  always_comb begin
    w_pos = 32'(r_idx) * DIGIT;
    w_ad = DIGIT'(r_result >> w_pos);
    w_bd = DIGIT'(r_b >> w_pos) ^ {DIGIT{r_sub}};
    w_lg = r_and ? (w_ad & w_bd) : r_or ? (w_ad | w_bd) : (w_ad ^ w_bd);
    w_d = r_logic ? {1'b0, w_lg} : {1'b0, w_ad} + {1'b0, w_bd} + {{DIGIT{1'b0}}, r_carry};
    w_mask = WIDTH'({DIGIT{1'b1}}) << w_pos;
    w_dw = WIDTH'(w_d[DIGIT-1:0]) << w_pos;
    w_last = (r_idx == LW'(NDIG - 1)) || w_early;
  end
`ifdef DSALU_EARLY_EXIT_EN
  logic [LW-1:0] r_len;
  logic [DIGIT-1:0] w_e;
  // Zero extension with no carry, or all-ones extension absorbing a carry, leaves every upper digit equal to A.
  assign w_e = DIGIT'(r_b >> (w_pos + DIGIT)) ^ {DIGIT{r_sub}};
  assign w_early = !r_logic && (r_idx >= r_len) && ((w_e == '0 && !w_d[DIGIT]) || (&w_e && w_d[DIGIT]));
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_len <= '0;
    else if (w_acc) r_len <= w_len;
`else
  assign w_early = 1'b0;
`endif
  assign w_acc = i_start && (r_state == S_IDLE);
  always_comb begin
    w_next = r_state;
    w_next = w_acc ? S_RUN : (r_state == S_RUN && w_last) ? S_IDLE : r_state;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_b <= '0;
      r_result <= '0;
      r_idx <= '0;
      r_sub <= 1'b0;
      r_and <= 1'b0;
      r_or <= 1'b0;
      r_logic <= 1'b0;
      r_carry <= 1'b0;
      r_done <= 1'b0;
      r_cout <= 1'b0;
    end else begin
      r_done <= (r_state == S_RUN) && w_last;
      if (w_acc) begin
        r_b <= w_b_ext;
        r_result <= i_word1;
        r_idx <= '0;
        r_sub <= i_op == 3'd1;
        r_and <= i_op == 3'd2;
        r_or <= i_op == 3'd3;
        r_logic <= i_op inside {3'd2, 3'd3, 3'd4};
        r_carry <= i_op == 3'd1;
      end else if (r_state == S_RUN) begin
        r_result <= (r_result & ~w_mask) | (w_dw & w_mask);
        r_carry <= w_d[DIGIT];
        r_idx <= r_idx + 1'b1;
        if (w_last) r_cout <= w_d[DIGIT];
      end
    end
  assign o_busy = r_state == S_RUN;
  assign o_done = r_done;
  assign o_result = r_result;
  assign o_carry_out = r_cout;
endmodule
